// File: rtl/hcsr04_emulador_pkg.sv
// hcsr04_emulador_pkg: shared state encoding, debug codes and 50 MHz timing defaults
package hcsr04_emulador_pkg;
  typedef enum logic [2:0] {INICIAL, MEDE_TRIGGER, ATRASO, ECHO_ALTO, RECUPERA} estado_t;
  localparam logic [3:0] DB_INICIAL = 4'b0000;
  localparam logic [3:0] DB_MEDE_TRIGGER = 4'b0001;
  localparam logic [3:0] DB_ATRASO = 4'b0010;
  localparam logic [3:0] DB_ECHO_ALTO = 4'b0011;
  localparam logic [3:0] DB_RECUPERA = 4'b0100;
  localparam logic [3:0] DB_INVALIDO = 4'b1110;
  localparam int TRIGGER_MIN_PADRAO = 500;
  localparam int ATRASO_PADRAO = 10000;
  localparam int POR_CM_PADRAO = 2941;
  localparam int RECUPERA_PADRAO = 50000;
  localparam int TIMEOUT_PADRAO = 1900000;
  localparam int DIST_MAX_PADRAO = 400;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
  // Without the timeout feature, 0 cm is stretched to 1 cm and far targets clamp to dmax.
  function automatic logic [8:0] cm_saturado(input logic [8:0] d, input int dmax);
    return d == '0 ? 9'd1 : (32'(d) > dmax ? 9'(dmax) : d);
  endfunction
endpackage

// File: rtl/hcsr04_emulador_if.sv
// hcsr04_emulador_if: trigger/echo bundle between interface unit (master) and sensor (slave)
// trigger, distancia: master -> sensor; echo, ocupado, db_estado: sensor -> master
interface hcsr04_emulador_if;
  logic trigger;
  logic [8:0] distancia;
  logic echo;
  logic ocupado;
  logic [3:0] db_estado;
  modport master(output trigger, distancia, input echo, ocupado, db_estado);
  modport slave(input trigger, distancia, output echo, ocupado, db_estado);
endinterface

// File: rtl/hcsr04_emulador_sincronizador_2ff.sv
// sincronizador_2ff: two-flop synchronizer for one asynchronous board input
// clock, reset (sync, active-high, clears both flops), d_i async in, q_o synchronized out
module sincronizador_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);
  logic meta_q, sinc_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= 1'b0;
      sinc_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sinc_q <= meta_q;
    end
  end
  assign q_o = sinc_q;
endmodule

// File: rtl/hcsr04_emulador.sv
// hcsr04_emulador: HC-SR04 responder, answers a valid trigger with a distance-coded echo pulse
// clock, reset (sync, active-high); sensor (slave modport): trigger, distancia in; echo, ocupado, db_estado out
// HCSR04_TIMEOUT_EN: out-of-range distances give a CICLOS_TIMEOUT echo instead of clamping
module hcsr04_emulador
  import hcsr04_emulador_pkg::*;
#(
  parameter int CICLOS_TRIGGER_MIN = TRIGGER_MIN_PADRAO,
  parameter int CICLOS_ATRASO = ATRASO_PADRAO,
  parameter int CICLOS_POR_CM = POR_CM_PADRAO,
  parameter int CICLOS_RECUPERA = RECUPERA_PADRAO,
  parameter int CICLOS_TIMEOUT = TIMEOUT_PADRAO,
  parameter int DIST_MAX = DIST_MAX_PADRAO
) (
  input logic clock,
  input logic reset,
  hcsr04_emulador_if.slave sensor
);
  localparam int CMAX = max_int(max_int(max_int(CICLOS_TRIGGER_MIN, CICLOS_ATRASO),
                                        max_int(CICLOS_POR_CM, CICLOS_RECUPERA)), CICLOS_TIMEOUT);
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] UM = CW'(1);
  localparam logic [CW-1:0] TMIN = CW'(CICLOS_TRIGGER_MIN);
  localparam logic [CW-1:0] FIM_ATR = CW'(CICLOS_ATRASO - 1);
  localparam logic [CW-1:0] FIM_CM = CW'(CICLOS_POR_CM - 1);
  localparam logic [CW-1:0] FIM_REC = CW'(CICLOS_RECUPERA - 1);
  localparam logic [CW-1:0] FIM_TOUT = CW'(CICLOS_TIMEOUT - 1);
  estado_t estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0] cm_q, cm_d, dist_q, dist_d;
  logic trig_s, trig_p_q, echo_q, fora, ult_sub, fim_echo;
  sincronizador_2ff u_sinc (.clock(clock), .reset(reset), .d_i(sensor.trigger), .q_o(trig_s));
`ifdef HCSR04_TIMEOUT_EN
  assign fora = dist_q == '0 || 32'(dist_q) > DIST_MAX;
`else
  assign fora = 1'b0;
`endif
  // cnt_q doubles as the sub-cm counter in echo_alto; cm_q counts the remaining centimetres.
  assign ult_sub = cnt_q == FIM_CM;
  assign fim_echo = fora ? cnt_q == FIM_TOUT : ult_sub && cm_q == 9'd1;
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= INICIAL;
      cnt_q <= '0;
      cm_q <= '0;
      dist_q <= '0;
      trig_p_q <= 1'b0;
      echo_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q <= cnt_d;
      cm_q <= cm_d;
      dist_q <= dist_d;
      trig_p_q <= trig_s;
      echo_q <= estado_d == ECHO_ALTO;
    end
  end
  always_comb begin
    estado_d = estado_q;
    cnt_d = cnt_q;
    cm_d = cm_q;
    dist_d = dist_q;
    case (estado_q)
      INICIAL: if (trig_s && !trig_p_q) begin
        estado_d = MEDE_TRIGGER;
        cnt_d = UM;
      end
      MEDE_TRIGGER: if (trig_s) cnt_d = cnt_q == TMIN ? cnt_q : cnt_q + UM;
      else begin
        estado_d = cnt_q >= TMIN ? ATRASO : INICIAL;
        dist_d = cnt_q >= TMIN ? sensor.distancia : dist_q;
        cnt_d = '0;
      end
      ATRASO: begin
        estado_d = cnt_q == FIM_ATR ? ECHO_ALTO : ATRASO;
        cnt_d = cnt_q == FIM_ATR ? '0 : cnt_q + UM;
        cm_d = cm_saturado(dist_q, DIST_MAX);
      end
      ECHO_ALTO: begin
        estado_d = fim_echo ? RECUPERA : ECHO_ALTO;
        cnt_d = fim_echo || (!fora && ult_sub) ? '0 : cnt_q + UM;
        cm_d = ult_sub ? cm_q - 9'd1 : cm_q;
      end
      RECUPERA: begin
        estado_d = cnt_q == FIM_REC ? INICIAL : RECUPERA;
        cnt_d = cnt_q == FIM_REC ? '0 : cnt_q + UM;
      end
      default: begin
        estado_d = INICIAL;
        cnt_d = '0;
      end
    endcase
  end
  always_comb begin
    sensor.ocupado = estado_q != INICIAL;
    case (estado_q)
      INICIAL: sensor.db_estado = DB_INICIAL;
      MEDE_TRIGGER: sensor.db_estado = DB_MEDE_TRIGGER;
      ATRASO: sensor.db_estado = DB_ATRASO;
      ECHO_ALTO: sensor.db_estado = DB_ECHO_ALTO;
      RECUPERA: sensor.db_estado = DB_RECUPERA;
      default: sensor.db_estado = DB_INVALIDO;
    endcase
  end
  assign sensor.echo = echo_q;
endmodule

// File: tb/tb_hcsr04_emulador.sv
// tb_hcsr04_emulador: directed bench with a timeline model of the sensor protocol
module tb_hcsr04_emulador;
  localparam int MIN = 5, ATR = 20, PCM = 3, REC = 10, TOUT = 100, DMAX = 400;
`ifdef HCSR04_TIMEOUT_EN
  localparam int L401 = 100, L0 = 100;
`else
  localparam int L401 = 1200, L0 = 3;
`endif
  logic clock = 1'b0;
  logic reset = 1'b1;
  hcsr04_emulador_if bus();
  hcsr04_emulador #(
    .CICLOS_TRIGGER_MIN(MIN), .CICLOS_ATRASO(ATR), .CICLOS_POR_CM(PCM),
    .CICLOS_RECUPERA(REC), .CICLOS_TIMEOUT(TOUT), .DIST_MAX(DMAX)
  ) dut (.clock(clock), .reset(reset), .sensor(bus));
  always #5 clock = ~clock;
  int checks = 0, errors = 0;
  int pulsos = 0, larg_ult = 0, larg_cur = 0, t_subida = 0, t_queda = 0, ocup_cnt = 0;
  logic [19:0] seq = '0;
  logic [3:0] db_ant = '0;
  logic echo_ant = 1'b0;
  function automatic int largura(input int d);
`ifdef HCSR04_TIMEOUT_EN
    return (d == 0 || d > DMAX) ? TOUT : d * PCM;
`else
    return d == 0 ? PCM : (d > DMAX ? DMAX * PCM : d * PCM);
`endif
  endfunction
  task automatic verifica(input string nome, input int atual, input int esperado);
    checks++;
    if (atual != esperado) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nome, atual, esperado);
    end
  endtask
  // Sensor timeline: a measurement starts when the synchronized trigger (input delayed two edges)
  // rises while idle; phases then follow from the fall edge f by plain arithmetic.
  initial begin : modelo
    int t, s, f, w, db_e;
    bit i0, i1, i2, i3, r0, busy, valido, wb;
    logic [8:0] d0;
    t = 0; s = 0; f = -1; w = 0;
    i0 = 0; i1 = 0; i2 = 0; i3 = 0; r0 = 1; busy = 0; valido = 0;
    d0 = '0;
    forever begin
      @(negedge clock);
      t++;
      if (r0) begin
        busy = 0;
        i0 = 0; i1 = 0; i2 = 0;
      end else begin
        wb = busy;
        if (busy && f >= 0 && t == f + ATR + w + REC) busy = 0;
        else if (busy && f < 0 && !i2) begin
          f = t;
          valido = (t - s) >= MIN;
          w = largura(int'(d0));
          if (!valido) busy = 0;
        end
        if (!wb && i2 && !i3) begin
          busy = 1;
          s = t;
          f = -1;
        end
      end
      db_e = !busy ? 0 : f < 0 ? 1 : t < f + ATR ? 2 : t < f + ATR + w ? 3 : 4;
      checks++;
      if (bus.db_estado !== 4'(db_e) || bus.echo !== (db_e == 3) || bus.ocupado !== (db_e != 0)) begin
        errors++;
        $display("FAIL saida t=%0d: echo=%b ocupado=%b db=%b expected echo=%b ocupado=%b db=%0d",
                 t, bus.echo, bus.ocupado, bus.db_estado, db_e == 3, db_e != 0, db_e);
      end
      if (bus.echo && !echo_ant) begin
        t_subida = t;
        larg_cur = 0;
      end
      if (bus.echo) larg_cur++;
      if (!bus.echo && echo_ant) begin
        pulsos++;
        larg_ult = larg_cur;
      end
      echo_ant = bus.echo;
      if (bus.ocupado) ocup_cnt++;
      if (bus.db_estado != db_ant) begin
        seq = {seq[15:0], bus.db_estado};
        db_ant = bus.db_estado;
      end
      if (i0 && !bus.trigger) t_queda = t + 1;
      i3 = i2; i2 = i1; i1 = i0;
      i0 = bus.trigger;
      r0 = reset;
      d0 = bus.distancia;
    end
  end
  task automatic pulso(input int h);
    @(posedge clock);
    #2 bus.trigger = 1'b1;
    repeat (h) @(posedge clock);
    #2 bus.trigger = 1'b0;
  endtask
  task automatic espera(input int n);
    repeat (n) @(posedge clock);
  endtask
  task automatic medida(input int d, input int h, input int n, input string nome, input int pulsos_esp, input int larg_esp);
    int p0;
    p0 = pulsos;
    #2 bus.distancia = 9'(d);
    pulso(h);
    espera(n);
    verifica({nome, "_pulsos"}, pulsos - p0, pulsos_esp);
    if (pulsos_esp > 0) verifica({nome, "_largura"}, larg_ult, larg_esp);
  endtask
  initial begin : estimulo
    int p0, o0;
    bus.trigger = 1'b0;
    bus.distancia = 9'd10;
    espera(3);
    #2 reset = 1'b0;
    medida(10, 6, 80, "t1", 1, 30);
    verifica("t1_atraso", t_subida - t_queda, 22);
    verifica("t1_estados", int'(seq), 'h12340);
    p0 = pulsos;
    o0 = ocup_cnt;
    pulso(3);
    espera(30);
    verifica("t2_pulsos", pulsos - p0, 0);
    verifica("t2_ocupado", ocup_cnt - o0, 3);
    verifica("t2_estados", int'(seq[15:0]), 'h4010);
    medida(10, 5, 80, "min5", 1, 30);
    medida(10, 4, 30, "min4", 0, 0);
    medida(401, 6, 1300, "d401", 1, L401);
    medida(0, 6, 200, "d0", 1, L0);
    medida(400, 6, 1300, "d400", 1, 1200);
    medida(1, 6, 60, "d1", 1, 3);
    p0 = pulsos;
    #2 bus.distancia = 9'd10;
    pulso(6);
    espera(25);
    pulso(6);
    espera(21);
    pulso(5);
    espera(30);
    verifica("t4_ignorados", pulsos - p0, 1);
    pulso(6);
    espera(52);
    #2 bus.trigger = 1'b1;
    espera(20);
    #2 bus.trigger = 1'b0;
    espera(20);
    verifica("t4_mantido", pulsos - p0, 2);
    medida(10, 6, 80, "t4_novo", 1, 30);
    pulso(6);
    espera(8);
    #2 bus.distancia = 9'd50;
    espera(70);
    verifica("t5_largura", larg_ult, 30);
    #2 bus.distancia = 9'd10;
    pulso(6);
    espera(35);
    verifica("t6_antes", int'(bus.echo), 1);
    #2 reset = 1'b1;
    @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    verifica("t6_echo", int'(bus.echo), 0);
    verifica("t6_estado", int'(bus.db_estado), 0);
    espera(10);
    medida(20, 6, 100, "t6_novo", 1, 60);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
